// File: rtl/pim_addr_seq.sv
// Address sequencer for the PIM datapath: loads src/dst base registers, then walks them one element per ack.
// Optional busy-cycle counter is compiled in when PIM_SEQ_PERF_EN is defined.
module pim_addr_seq #(
    parameter int N     = 10,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [1:0]       instr_op,
    input  logic [N-1:0]     instr_src,
    input  logic [N-1:0]     instr_dst,
    input  logic [LEN_W-1:0] instr_len,
    output logic [N-1:0]     src_d,
    output logic [N-1:0]     dst_d,
    output logic [N-1:0]     src_mov_in,
    output logic             src_pim_load,
    output logic             dst_pim_load,
    output logic             src_mov_load,
    output logic             src_update_load,
    output logic             dst_update_load,
    output logic             op_req,
    input  logic             op_ack,
    output logic [N-1:0]     op_src_addr,
    output logic [N-1:0]     op_dst_addr,
    output logic             busy,
    output logic             done,
    output logic             err_wrap,
`ifdef PIM_SEQ_PERF_EN
    output logic             err_op,
    output logic [15:0]      busy_cycles
`else
    output logic             err_op
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_PIM = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [N-1:0]     src_q;
    logic [N-1:0]     dst_q;
    logic [LEN_W-1:0] remaining;
    logic [N-1:0]     shadow_src;
    logic [N-1:0]     shadow_dst;
    logic             accept;
    logic             runs_elements;

    assign accept        = instr_valid && (state == IDLE);
    assign runs_elements = ((instr_op == OP_PIM) || (instr_op == OP_MOV)) && (instr_len != '0);

    // Register-side data is the captured instruction; it only changes on accept, so it is stable in LOAD.
    assign src_d       = src_q;
    assign dst_d       = dst_q;
    assign src_mov_in  = src_q;
    assign op_src_addr = shadow_src;
    assign op_dst_addr = shadow_dst;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        instr_ready     = 1'b0;
        src_pim_load    = 1'b0;
        dst_pim_load    = 1'b0;
        src_mov_load    = 1'b0;
        src_update_load = 1'b0;
        dst_update_load = 1'b0;
        op_req          = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = runs_elements ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (op_q == OP_PIM) begin
                    src_pim_load = 1'b1;
                    dst_pim_load = 1'b1;
                end else begin
                    src_mov_load = 1'b1;
                end
                state_nxt = ISSUE;
            end
            ISSUE: begin
                op_req = 1'b1;
                if (op_ack) begin
                    state_nxt = (remaining == LEN_W'(1)) ? DONE : STEP;
                end
            end
            STEP: begin
                src_update_load = 1'b1;
                dst_update_load = 1'b1;
                state_nxt       = ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            remaining  <= '0;
            shadow_src <= '0;
            shadow_dst <= '0;
            err_wrap   <= 1'b0;
            err_op     <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= instr_op;
                src_q     <= instr_src;
                dst_q     <= instr_dst;
                remaining <= instr_len;
                err_wrap  <= 1'b0;
                err_op    <= (instr_op == OP_RSV);
            end
            // MOV leaves the destination shadow alone so it continues from the previous instruction.
            if (state == LOAD) begin
                shadow_src <= src_q;
                if (op_q == OP_PIM) begin
                    shadow_dst <= dst_q;
                end
            end
            if ((state == ISSUE) && op_ack) begin
                remaining <= remaining - LEN_W'(1);
            end
            if (state == STEP) begin
                shadow_src <= shadow_src + N'(1);
                shadow_dst <= shadow_dst + N'(1);
                if ((&shadow_src) || (&shadow_dst)) begin
                    err_wrap <= 1'b1;
                end
            end
        end
    end

`ifdef PIM_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles <= '0;
        end else if (accept) begin
            busy_cycles <= '0;
        end else if (busy && (busy_cycles != 16'hFFFF)) begin
            busy_cycles <= busy_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pim_addr_seq.sv
// Self-checking bench for pim_addr_seq: scoreboard of expected (src,dst) request pairs plus per-scenario checks.
module tb_pim_addr_seq;
    localparam int N     = 10;
    localparam int LEN_W = 8;
    localparam int W     = 2 * N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [1:0]       instr_op;
    logic [N-1:0]     instr_src;
    logic [N-1:0]     instr_dst;
    logic [LEN_W-1:0] instr_len;
    logic [N-1:0]     src_d;
    logic [N-1:0]     dst_d;
    logic [N-1:0]     src_mov_in;
    logic             src_pim_load;
    logic             dst_pim_load;
    logic             src_mov_load;
    logic             src_update_load;
    logic             dst_update_load;
    logic             op_req;
    logic             op_ack;
    logic [N-1:0]     op_src_addr;
    logic [N-1:0]     op_dst_addr;
    logic             busy;
    logic             done;
    logic             err_wrap;
    logic             err_op;
`ifdef PIM_SEQ_PERF_EN
    logic [15:0]      busy_cycles;
`endif

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int n_req, n_src_upd, n_dst_upd, n_src_pim, n_dst_pim, n_mov, n_done;
    bit ack_tied  = 1'b1;
    int ack_delay = 0;
    int wait_cnt  = 0;
    logic [N-1:0] model_dst = '0;

    pim_addr_seq #(.N(N), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_op        (instr_op),
        .instr_src       (instr_src),
        .instr_dst       (instr_dst),
        .instr_len       (instr_len),
        .src_d           (src_d),
        .dst_d           (dst_d),
        .src_mov_in      (src_mov_in),
        .src_pim_load    (src_pim_load),
        .dst_pim_load    (dst_pim_load),
        .src_mov_load    (src_mov_load),
        .src_update_load (src_update_load),
        .dst_update_load (dst_update_load),
        .op_req          (op_req),
        .op_ack          (op_ack),
        .op_src_addr     (op_src_addr),
        .op_dst_addr     (op_dst_addr),
        .busy            (busy),
        .done            (done),
        .err_wrap        (err_wrap),
`ifdef PIM_SEQ_PERF_EN
        .err_op          (err_op),
        .busy_cycles     (busy_cycles)
`else
        .err_op          (err_op)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ack driver: tied high, or raised after ack_delay waiting cycles of op_req
    always @(posedge clk) begin
        #1;
        if (ack_tied) begin
            op_ack = 1'b1;
        end else if (op_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                op_ack   = 1'b1;
                wait_cnt = 0;
            end else begin
                op_ack   = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            op_ack   = 1'b0;
            wait_cnt = 0;
        end
    end

    // monitor / scoreboard: sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (src_pim_load)    n_src_pim++;
            if (dst_pim_load)    n_dst_pim++;
            if (src_mov_load)    n_mov++;
            if (src_update_load) n_src_upd++;
            if (dst_update_load) n_dst_upd++;
            if (done)            n_done++;
            if (op_req === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL req_unexpected got=%h/%h want=none", op_src_addr, op_dst_addr);
                end else begin
                    logic [W-1:0] exp;
                    exp = (op_ack === 1'b1) ? exp_q.pop_front() : exp_q[0];
                    if ({op_src_addr, op_dst_addr} !== exp) begin
                        bad++;
                        $display("FAIL req_addr got=%h/%h want=%h/%h ack=%b",
                                 op_src_addr, op_dst_addr, exp[W-1:N], exp[N-1:0], op_ack);
                    end
                end
                if (op_ack === 1'b1) n_req++;
            end
        end
    end

    // driver: pushes expected requests, runs one handshake, waits for done, then one more cycle.
    // Called aligned to 1 time unit after a rising edge; returns aligned the same way, in IDLE.
    task automatic drive_instr(input logic [1:0] op, input logic [N-1:0] src, input logic [N-1:0] dst,
                               input logic [LEN_W-1:0] len, output int cyc, output int exp_n,
                               output bit exp_wrap, output logic [2:0] ld_seen,
                               output logic [3*N-1:0] ld_data);
        logic [N-1:0] s;
        logic [N-1:0] d;
        bit active;
        active   = ((op == 2'b01) || (op == 2'b10)) && (len != '0);
        s        = src;
        d        = (op == 2'b01) ? dst : model_dst;
        exp_wrap = 1'b0;
        exp_n    = active ? int'(len) : 0;
        for (int i = 0; i < exp_n; i++) begin
            exp_q.push_back({s, d});
            if (i < exp_n - 1) begin
                if ((s == '1) || (d == '1)) exp_wrap = 1'b1;
                s = s + 1'b1;
                d = d + 1'b1;
            end
        end
        if (active) model_dst = d;
        n_req = 0; n_src_upd = 0; n_dst_upd = 0; n_src_pim = 0; n_dst_pim = 0; n_mov = 0; n_done = 0;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_src   = src;
        instr_dst   = dst;
        instr_len   = len;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_op    = 2'($urandom_range(0, 3));
        instr_src   = N'($urandom);
        instr_dst   = N'($urandom);
        instr_len   = LEN_W'($urandom);
        cyc     = 1;
        ld_seen = {src_pim_load, dst_pim_load, src_mov_load};
        ld_data = {src_d, dst_d, src_mov_in};
        while ((done !== 1'b1) && (cyc < 2000)) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done !== 1'b1) exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_src   = '0;
        instr_dst   = '0;
        instr_len   = '0;
        op_ack      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({instr_ready, busy, op_req, done, err_wrap, err_op, src_pim_load, dst_pim_load,
             src_mov_load, src_update_load, dst_update_load} !== 11'b100_0000_0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b", {instr_ready, busy, op_req, done, err_wrap, err_op,
                     src_pim_load, dst_pim_load, src_mov_load, src_update_load, dst_update_load}, 11'b100_0000_0000);
        end
        total++;
        if ({src_d, dst_d, src_mov_in, op_src_addr, op_dst_addr} !== '0) begin
            bad++;
            $display("FAIL reset_addr got=%h/%h/%h/%h/%h want=0", src_d, dst_d, src_mov_in, op_src_addr, op_dst_addr);
        end
`ifdef PIM_SEQ_PERF_EN
        total++;
        if (busy_cycles !== 16'd0) begin
            bad++;
            $display("FAIL reset_busy_cycles got=%0d want=0", busy_cycles);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_pim_basic();
        int cyc, exp_n;
        bit ew;
        logic [2:0] ls;
        logic [3*N-1:0] ld;
        ack_tied = 1'b1;
        drive_instr(2'b01, 10'h010, 10'h200, 8'd3, cyc, exp_n, ew, ls, ld);
        total++;
        if ((ls !== 3'b110) || (ld[3*N-1:N] !== {10'h010, 10'h200})) begin
            bad++;
            $display("FAIL pim_load got=%b %h/%h want=110 010/200", ls, ld[3*N-1:2*N], ld[2*N-1:N]);
        end
        total++;
        if (cyc !== 7) begin
            bad++;
            $display("FAIL pim_done_cycle got=%0d want=7", cyc);
        end
        total++;
        if ({n_req, n_src_upd, n_dst_upd, n_done} !== {32'd3, 32'd2, 32'd2, 32'd1}) begin
            bad++;
            $display("FAIL pim_counts got=req%0d upd%0d/%0d done%0d want=req3 upd2/2 done1",
                     n_req, n_src_upd, n_dst_upd, n_done);
        end
        total++;
        if ((err_wrap !== 1'b0) || (instr_ready !== 1'b1) || (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL pim_end got=wrap%b rdy%b q%0d want=wrap0 rdy1 q0", err_wrap, instr_ready, exp_q.size());
        end
`ifdef PIM_SEQ_PERF_EN
        total++;
        if (busy_cycles !== 16'd7) begin
            bad++;
            $display("FAIL pim_busy_cycles got=%0d want=7", busy_cycles);
        end
`endif
    endtask

    task automatic test_ack_delay();
        int cyc, exp_n;
        bit ew;
        logic [2:0] ls;
        logic [3*N-1:0] ld;
        ack_tied  = 1'b0;
        ack_delay = 4;
        drive_instr(2'b01, 10'h100, 10'h004, 8'd2, cyc, exp_n, ew, ls, ld);
        total++;
        if ({n_req, n_done, cyc} !== {32'd2, 32'd1, 32'd13}) begin
            bad++;
            $display("FAIL ack_delay got=req%0d done%0d cyc%0d want=req2 done1 cyc13", n_req, n_done, cyc);
        end
        total++;
        if ({n_src_upd, n_dst_upd} !== {32'd1, 32'd1} || exp_q.size() != 0) begin
            bad++;
            $display("FAIL ack_delay_upd got=%0d/%0d q%0d want=1/1 q0", n_src_upd, n_dst_upd, exp_q.size());
        end
        ack_tied = 1'b1;
    endtask

    task automatic test_mov_wrap();
        int cyc, exp_n;
        bit ew;
        logic [2:0] ls;
        logic [3*N-1:0] ld;
        ack_tied = 1'b1;
        drive_instr(2'b10, 10'h3FE, 10'h123, 8'd3, cyc, exp_n, ew, ls, ld);
        total++;
        if ((ls !== 3'b001) || (ld[N-1:0] !== 10'h3FE)) begin
            bad++;
            $display("FAIL mov_load got=%b %h want=001 3fe", ls, ld[N-1:0]);
        end
        total++;
        if ((err_wrap !== 1'b1) || (cyc !== 7) || (n_req !== 3) || (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL mov_wrap got=wrap%b cyc%0d req%0d q%0d want=wrap1 cyc7 req3 q0",
                     err_wrap, cyc, n_req, exp_q.size());
        end
        total++;
        if ({n_src_pim, n_dst_pim, n_mov} !== {32'd0, 32'd0, 32'd1}) begin
            bad++;
            $display("FAIL mov_strobes got=%0d/%0d/%0d want=0/0/1", n_src_pim, n_dst_pim, n_mov);
        end
    endtask

    task automatic test_nop_reserved();
        int cyc, exp_n;
        bit ew;
        logic [2:0] ls;
        logic [3*N-1:0] ld;
        drive_instr(2'b01, 10'h055, 10'h066, 8'd0, cyc, exp_n, ew, ls, ld);
        total++;
        if ((cyc !== 1) || (ls !== 3'b000) || (n_req !== 0) || (err_op !== 1'b0) || (instr_ready !== 1'b1)) begin
            bad++;
            $display("FAIL len0 got=cyc%0d ld%b req%0d errop%b rdy%b want=cyc1 ld000 req0 errop0 rdy1",
                     cyc, ls, n_req, err_op, instr_ready);
        end
        drive_instr(2'b11, 10'h077, 10'h088, 8'd4, cyc, exp_n, ew, ls, ld);
        total++;
        if ((cyc !== 1) || (n_req !== 0) || (err_op !== 1'b1) || (instr_ready !== 1'b1) ||
            ({n_src_pim, n_mov, n_src_upd} !== {32'd0, 32'd0, 32'd0})) begin
            bad++;
            $display("FAIL reserved got=cyc%0d req%0d errop%b rdy%b want=cyc1 req0 errop1 rdy1",
                     cyc, n_req, err_op, instr_ready);
        end
        drive_instr(2'b00, 10'h099, 10'h0AA, 8'd5, cyc, exp_n, ew, ls, ld);
        total++;
        if ((cyc !== 1) || (n_req !== 0) || (err_op !== 1'b0) || (n_done !== 1)) begin
            bad++;
            $display("FAIL nop got=cyc%0d req%0d errop%b done%0d want=cyc1 req0 errop0 done1",
                     cyc, n_req, err_op, n_done);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, exp_n, k, nd;
        bit ew;
        logic [2:0] ls;
        logic [3*N-1:0] ld;
        ack_tied  = 1'b0;
        ack_delay = 50;
        exp_q.push_back({10'h020, 10'h030});
        instr_valid = 1'b1;
        instr_op    = 2'b01;
        instr_src   = 10'h020;
        instr_dst   = 10'h030;
        instr_len   = 8'd5;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        k = 0;
        while ((op_req !== 1'b1) && (k < 10)) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (op_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_reach_issue got=%b want=1", op_req);
        end
        @(posedge clk); #2;
        nd    = n_done;
        rst_n = 1'b0;
        #1;
        total++;
        if ({instr_ready, busy, op_req, done, err_wrap, err_op, src_pim_load, src_update_load} !== 8'b1000_0000 ||
            {src_d, dst_d, src_mov_in, op_src_addr, op_dst_addr} !== '0) begin
            bad++;
            $display("FAIL mid_reset got=rdy%b busy%b req%b src%h dst%h want=rdy1 busy0 req0 src0 dst0",
                     instr_ready, busy, op_req, op_src_addr, op_dst_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        model_dst = '0;
        ack_tied  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ((n_done !== nd) || (done !== 1'b0) || (instr_ready !== 1'b1)) begin
            bad++;
            $display("FAIL mid_no_done got=%0d rdy%b want=%0d rdy1", n_done, instr_ready, nd);
        end
        drive_instr(2'b01, 10'h3FF, 10'h3FD, 8'd3, cyc, exp_n, ew, ls, ld);
        total++;
        if ((cyc !== 7) || (n_req !== 3) || (err_wrap !== 1'b1) || (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL after_reset got=cyc%0d req%0d wrap%b q%0d want=cyc7 req3 wrap1 q0",
                     cyc, n_req, err_wrap, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int cyc, exp_n;
        bit ew;
        logic [1:0] op;
        logic [2:0] ls;
        logic [3*N-1:0] ld;
        ack_tied = 1'b1;
        drive_instr(2'b01, 10'h3F0, 10'h000, 8'd255, cyc, exp_n, ew, ls, ld);
        total++;
        if ((cyc !== 511) || (n_req !== 255) || (n_src_upd !== 254) || (err_wrap !== 1'b1) || (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL max_len got=cyc%0d req%0d upd%0d wrap%b want=cyc511 req255 upd254 wrap1",
                     cyc, n_req, n_src_upd, err_wrap);
        end
        ack_tied = 1'b0;
        for (int t = 0; t < 10; t++) begin
            op        = 2'($urandom_range(0, 3));
            ack_delay = $urandom_range(0, 2);
            drive_instr(op, N'($urandom_range(1016, 1023)), N'($urandom), LEN_W'($urandom_range(0, 6)),
                        cyc, exp_n, ew, ls, ld);
            total++;
            if ((n_done !== 1) || (n_req !== exp_n) || (n_src_upd !== ((exp_n > 0) ? exp_n - 1 : 0)) ||
                (err_wrap !== ew) || (err_op !== (op == 2'b11)) || (exp_q.size() != 0)) begin
                bad++;
                $display("FAIL b2b_%0d got=done%0d req%0d upd%0d wrap%b errop%b want=done1 req%0d upd%0d wrap%b errop%b",
                         t, n_done, n_req, n_src_upd, err_wrap, err_op, exp_n,
                         (exp_n > 0) ? exp_n - 1 : 0, ew, (op == 2'b11));
            end
        end
        ack_tied = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pim_basic();
        test_ack_delay();
        test_mov_wrap();
        test_nop_reserved();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
